// File: rtl/board_io_if.sv
// Pin-side bundle for board_io: raw buttons in, debounced levels/press pulses out,
// LED requests and brightness in, gated LED pins out.
interface board_io_if #(
  parameter int LED_COUNT = 8,
  parameter int BTN_COUNT = 4,
  parameter int PWM_BITS  = 4
);
  logic [BTN_COUNT-1:0] btn_i;
  logic [BTN_COUNT-1:0] btn_o;
  logic [BTN_COUNT-1:0] btn_press_o;
  logic [LED_COUNT-1:0] led_i;
  logic [PWM_BITS-1:0]  led_bright_i;
  logic [LED_COUNT-1:0] led_o;

  modport slave (
    input  btn_i, led_i, led_bright_i,
    output btn_o, btn_press_o, led_o
  );

  modport master (
    output btn_i, led_i, led_bright_i,
    input  btn_o, btn_press_o, led_o
  );
endinterface

// File: rtl/board_io.sv
// Board I/O conditioner: soc reset generator, button debouncer, LED PWM gating.
// Optional heartbeat on the top LED when BOARD_IO_HEARTBEAT_EN is defined.
module board_io #(
  parameter int LED_COUNT       = 8,
  parameter int BTN_COUNT       = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int POR_CYCLES      = 16,
  parameter int PWM_BITS        = 4,
  parameter int HB_BITS         = 26
) (
  input  logic       soc_clk_i,
  input  logic       soc_rst_ni,
  output logic       rst_o,
  board_io_if.slave  io
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("board_io: DEBOUNCE_CYCLES must be >= 2");
  end
  if (POR_CYCLES < 1) begin : g_bad_por
    $error("board_io: POR_CYCLES must be >= 1");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm
    $error("board_io: PWM_BITS must be >= 1");
  end
  if (HB_BITS < 1) begin : g_bad_hb
    $error("board_io: HB_BITS must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Reset generator
  // ---------------------------------------------------------------------------
  logic [1:0]       rst_sync_q;
  logic             rst_q, rst_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;

  always_comb begin
    rst_d     = rst_q;
    por_cnt_d = por_cnt_q;
    if (rst_sync_q[1] && rst_q) begin
      if (por_cnt_q == POR_LAST) begin
        rst_d     = 1'b0;
        por_cnt_d = '0;
      end else begin
        por_cnt_d = por_cnt_q + POR_W'(1);
      end
    end
  end

  // rst_q is preset asynchronously so the soc sees reset the moment the pin drops.
  always_ff @(posedge soc_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      rst_sync_q <= 2'b00;
      rst_q      <= 1'b1;
      por_cnt_q  <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      rst_q      <= rst_d;
      por_cnt_q  <= por_cnt_d;
    end
  end

  assign rst_o = rst_q;

  // ---------------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------------
  logic [BTN_COUNT-1:0] btn_meta_q;
  logic [BTN_COUNT-1:0] btn_sync_q;
  logic [BTN_COUNT-1:0] btn_q, btn_d;
  logic [BTN_COUNT-1:0] press_q, press_d;
  logic [DB_W-1:0]      db_cnt_q [BTN_COUNT];
  logic [DB_W-1:0]      db_cnt_d [BTN_COUNT];

  always_comb begin
    btn_d   = btn_q;
    press_d = '0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (btn_sync_q[i] == btn_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        btn_d[i]    = btn_sync_q[i];
        press_d[i]  = btn_sync_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Synchronisers are held clear with the rest of the channel while the soc is in reset.
  always_ff @(posedge soc_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_q      <= '0;
      press_q    <= '0;
      for (int i = 0; i < BTN_COUNT; i++) db_cnt_q[i] <= '0;
    end else if (rst_q) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_q      <= '0;
      press_q    <= '0;
      for (int i = 0; i < BTN_COUNT; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_meta_q <= io.btn_i;
      btn_sync_q <= btn_meta_q;
      btn_q      <= btn_d;
      press_q    <= press_d;
      for (int i = 0; i < BTN_COUNT; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign io.btn_o       = btn_q;
  assign io.btn_press_o = press_q;

  // ---------------------------------------------------------------------------
  // LED PWM
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic                 pwm_en;
  logic [LED_COUNT-1:0] led_q, led_d;

  // All-ones brightness is forced fully on; the compare alone would top out one step short.
  assign pwm_en = (io.led_bright_i == '1) || (pwm_cnt_q < io.led_bright_i);

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_cnt_q;

  always_ff @(posedge soc_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      hb_cnt_q <= '0;
    end else if (rst_q) begin
      hb_cnt_q <= '0;
    end else begin
      hb_cnt_q <= hb_cnt_q + HB_BITS'(1);
    end
  end

  always_comb begin
    led_d                = io.led_i & {LED_COUNT{pwm_en}};
    led_d[LED_COUNT-1]   = hb_cnt_q[HB_BITS-1];
  end
`else
  always_comb begin
    led_d = io.led_i & {LED_COUNT{pwm_en}};
  end
`endif

  always_ff @(posedge soc_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else if (rst_q) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= led_d;
    end
  end

  assign io.led_o = led_q;

endmodule
